// File: rtl/fphub_norm_pkg.sv
// Shared types and sizing helpers for the FPHUB normalizer.
// Optional build macro: FPHUB_NORM_SINGLE_CYCLE_EN (see fphub_normalizer.sv).
package fphub_norm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_e;

    function automatic int calc_w(input int m, input int extra_bits);
        return m + extra_bits - 1;
    endfunction

    localparam int M_DEF           = 23;
    localparam int E_DEF           = 8;
    localparam int EXTRA_BITS_DEF  = 7;
    localparam int W_DEF           = calc_w(M_DEF, EXTRA_BITS_DEF);
    localparam int SHIFT_WIDTH_DEF = $clog2(W_DEF - 1);
    localparam int STEP_DEF        = 8;

    // LZD encoding for an all-zero mantissa: top bit set, count bits clear.
    localparam logic [SHIFT_WIDTH_DEF:0] ZERO_FLAG = {1'b1, {SHIFT_WIDTH_DEF{1'b0}}};

endpackage

// File: rtl/fphub_normalizer_if.sv
// Upstream (LZD side) and downstream (rounding side) handshakes of the normalizer.
interface fphub_normalizer_if #(
    parameter int W  = 29,
    parameter int E  = 8,
    parameter int SW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  mant_in;
    logic [E-1:0]  exp_in;
    logic          sign_in;
    logic [SW:0]   shift_amt;

    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  mant_out;
    logic [E-1:0]  exp_out;
    logic          sign_out;
    logic          zero_out;
    logic          underflow_out;

    modport slave (
        input  in_valid, mant_in, exp_in, sign_in, shift_amt, out_ready,
        output in_ready, out_valid, mant_out, exp_out, sign_out, zero_out, underflow_out
    );

    modport master (
        output in_valid, mant_in, exp_in, sign_in, shift_amt, out_ready,
        input  in_ready, out_valid, mant_out, exp_out, sign_out, zero_out, underflow_out
    );
endinterface

// File: rtl/fphub_norm_shift_step.sv
// One bounded left-shift step: shifts by min(rem_i, STEP) and reports what is left.
module fphub_norm_shift_step #(
    parameter int W    = 29,
    parameter int SW   = 5,
    parameter int STEP = 8
) (
    input  logic [W-1:0]  mant_i,
    input  logic [SW-1:0] rem_i,
    output logic [W-1:0]  mant_o,
    output logic [SW-1:0] rem_o
);
    localparam logic [SW-1:0] STEP_C = SW'(STEP);

    logic [SW-1:0] amt_s;

    // Clamp the shift to the per-step limit, then shift with zero fill.
    always_comb begin
        if (rem_i < STEP_C) begin
            amt_s = rem_i;
        end else begin
            amt_s = STEP_C;
        end
        mant_o = mant_i << amt_s;
        rem_o  = rem_i - amt_s;
    end
endmodule

// File: rtl/fphub_normalizer.sv
// Normalizes an LZD-annotated HUB mantissa and adjusts its exponent.
// Define FPHUB_NORM_SINGLE_CYCLE_EN to do the whole shift in the accept cycle.
module fphub_normalizer
    import fphub_norm_pkg::*;
#(
    parameter int M          = 23,
    parameter int E          = 8,
    parameter int EXTRA_BITS = 7,
    parameter int STEP       = 8,
    localparam int W         = calc_w(M, EXTRA_BITS),
    localparam int SW        = $clog2(W - 1)
) (
    input logic clk,
    input logic rst,
    fphub_normalizer_if.slave bus
);
`ifdef FPHUB_NORM_SINGLE_CYCLE_EN
    // A step as wide as the largest count turns the step unit into a full barrel shifter.
    localparam int STEP_EFF = (1 << SW) - 1;
`else
    localparam int STEP_EFF = STEP;
`endif
    localparam int CW = (E > SW) ? E : SW;

    norm_state_e   state_q;
    logic [W-1:0]  mant_q;
    logic [E-1:0]  exp_q;
    logic          sign_q;
    logic          zero_q;
    logic          uf_q;
    logic [SW-1:0] rem_q;

    logic [SW-1:0] n_s;
    logic          n_gt_exp_s;
    logic [E-1:0]  exp_sub_s;
    logic [W-1:0]  step_mant_s;
    logic [SW-1:0] step_rem_s;
    logic [W-1:0]  mant_d;
    logic [SW-1:0] rem_d;

    assign n_s        = bus.shift_amt[SW-1:0];
    assign n_gt_exp_s = CW'(n_s) > CW'(bus.exp_in);
    assign exp_sub_s  = bus.exp_in - E'(n_s);

    // Feed the shifter from the incoming operand while idle, else from the held operand.
    always_comb begin
        if (state_q == IDLE) begin
            step_mant_s = bus.mant_in;
            step_rem_s  = n_s;
        end else begin
            step_mant_s = mant_q;
            step_rem_s  = rem_q;
        end
    end

    fphub_norm_shift_step #(
        .W    (W),
        .SW   (SW),
        .STEP (STEP_EFF)
    ) u_shift_step (
        .mant_i (step_mant_s),
        .rem_i  (step_rem_s),
        .mant_o (mant_d),
        .rem_o  (rem_d)
    );

    // Control FSM with all result fields held in registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mant_q  <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            uf_q    <= 1'b0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q <= bus.sign_in;
                        zero_q <= 1'b0;
                        uf_q   <= 1'b0;
                        rem_q  <= '0;
                        if (bus.shift_amt[SW]) begin
                            mant_q  <= '0;
                            exp_q   <= '0;
                            zero_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (n_gt_exp_s) begin
                            mant_q  <= '0;
                            exp_q   <= '0;
                            uf_q    <= 1'b1;
                            state_q <= DONE;
                        end else if (n_s == '0) begin
                            mant_q  <= bus.mant_in;
                            exp_q   <= bus.exp_in;
                            state_q <= DONE;
                        end else begin
                            exp_q   <= exp_sub_s;
`ifdef FPHUB_NORM_SINGLE_CYCLE_EN
                            mant_q  <= mant_d;
                            state_q <= DONE;
`else
                            mant_q  <= bus.mant_in;
                            rem_q   <= n_s;
                            state_q <= SHIFT;
`endif
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    mant_q <= mant_d;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= SHIFT;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.out_valid     = (state_q == DONE);
    assign bus.mant_out      = mant_q;
    assign bus.exp_out       = exp_q;
    assign bus.sign_out      = sign_q;
    assign bus.zero_out      = zero_q;
    assign bus.underflow_out = uf_q;
endmodule

// File: tb/tb_fphub_normalizer.sv
// Directed self-checking bench for fphub_normalizer (default W=29, E=8, STEP=8).
module tb_fphub_normalizer;
    import fphub_norm_pkg::*;

    localparam int W  = 29;
    localparam int E  = 8;
    localparam int SW = 5;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    fphub_normalizer_if #(.W(W), .E(E), .SW(SW)) bus_if ();

    fphub_normalizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected cycles from the accept edge to out_valid.
    function automatic int lat_of(input int n, input bit direct);
`ifdef FPHUB_NORM_SINGLE_CYCLE_EN
        return 1;
`else
        if (direct || n == 0) return 1;
        return 1 + (n + 7) / 8;
`endif
    endfunction

    // Issue one operand and leave the bench at the first negedge after the accept edge.
    task automatic send(input string tag, input logic [W-1:0] m, input logic [E-1:0] e,
                        input logic s, input logic [SW:0] sa);
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(bus_if.in_ready), 64'd1);
        bus_if.in_valid  = 1'b1;
        bus_if.mant_in   = m;
        bus_if.exp_in    = e;
        bus_if.sign_in   = s;
        bus_if.shift_amt = sa;
        @(negedge clk);
        bus_if.in_valid  = 1'b0;
        bus_if.mant_in   = '0;
        bus_if.shift_amt = '0;
    endtask

    task automatic run_case(input string tag, input logic [W-1:0] m, input logic [E-1:0] e,
                            input logic s, input logic [SW:0] sa,
                            input logic [W-1:0] xm, input logic [E-1:0] xe,
                            input logic xz, input logic xu, input int xlat, input int hold);
        int lat;
        send(tag, m, e, s, sa);
        lat = 1;
        while (!bus_if.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(xlat));
        chk({tag, ".mant"},    64'(bus_if.mant_out), 64'(xm));
        chk({tag, ".exp"},     64'(bus_if.exp_out), 64'(xe));
        chk({tag, ".sign"},    64'(bus_if.sign_out), 64'(s));
        chk({tag, ".zero"},    64'(bus_if.zero_out), 64'(xz));
        chk({tag, ".uf"},      64'(bus_if.underflow_out), 64'(xu));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 64'(bus_if.out_valid), 64'd1);
            chk({tag, ".hold_ready"}, 64'(bus_if.in_ready), 64'd0);
            chk({tag, ".hold_mant"},  64'(bus_if.mant_out), 64'(xm));
            chk({tag, ".hold_exp"},   64'(bus_if.exp_out), 64'(xe));
        end
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        chk({tag, ".rel_ready"}, 64'(bus_if.in_ready), 64'd1);
        chk({tag, ".rel_valid"}, 64'(bus_if.out_valid), 64'd0);
    endtask

    initial begin
        int seen;
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.mant_in   = '0;
        bus_if.exp_in    = '0;
        bus_if.sign_in   = 1'b0;
        bus_if.shift_amt = '0;
        bus_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.in_ready",  64'(bus_if.in_ready), 64'd1);
        chk("rst.out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("rst.mant",      64'(bus_if.mant_out), 64'd0);
        chk("rst.flags",     64'({bus_if.sign_out, bus_if.zero_out, bus_if.underflow_out}), 64'd0);
        rst = 1'b0;

        run_case("norm",  29'h1000_0000, 8'd100, 1'b1, 6'd0,
                 29'h1000_0000, 8'd100, 1'b0, 1'b0, lat_of(0, 1'b0), 0);
        run_case("deep",  29'h0000_0001, 8'd100, 1'b0, 6'd28,
                 29'h1000_0000, 8'd72, 1'b0, 1'b0, lat_of(28, 1'b0), 0);
        run_case("zero",  29'h0000_0000, 8'd50, 1'b1, ZERO_FLAG,
                 29'h0000_0000, 8'd0, 1'b1, 1'b0, lat_of(0, 1'b1), 0);
        run_case("uflow", 29'h0000_0400, 8'd5, 1'b0, 6'd18,
                 29'h0000_0000, 8'd0, 1'b0, 1'b1, lat_of(18, 1'b1), 0);
        run_case("mid18", 29'h0000_0400, 8'd30, 1'b1, 6'd18,
                 29'h1000_0000, 8'd12, 1'b0, 1'b0, lat_of(18, 1'b0), 0);
        run_case("step8", 29'h0010_0000, 8'd20, 1'b0, 6'd8,
                 29'h1000_0000, 8'd12, 1'b0, 1'b0, lat_of(8, 1'b0), 0);
        run_case("n_eq_e", 29'h0008_0000, 8'd9, 1'b0, 6'd9,
                 29'h1000_0000, 8'd0, 1'b0, 1'b0, lat_of(9, 1'b0), 0);
        run_case("over",  29'h0000_0001, 8'd100, 1'b1, 6'd30,
                 29'h0000_0000, 8'd70, 1'b0, 1'b0, lat_of(30, 1'b0), 0);
        run_case("bp",    29'h0200_0000, 8'd40, 1'b1, 6'd3,
                 29'h1000_0000, 8'd37, 1'b0, 1'b0, lat_of(3, 1'b0), 3);

        // Reset while the deep case is in its second shift cycle.
        send("rstmid", 29'h0000_0001, 8'd100, 1'b1, 6'd28);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid.in_ready",  64'(bus_if.in_ready), 64'd1);
        chk("rstmid.out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("rstmid.mant",      64'(bus_if.mant_out), 64'd0);
        chk("rstmid.exp",       64'(bus_if.exp_out), 64'd0);
        chk("rstmid.flags",     64'({bus_if.sign_out, bus_if.zero_out, bus_if.underflow_out}), 64'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_if.out_valid) seen++;
        end
        chk("rstmid.no_stale", 64'(seen), 64'd0);

        run_case("after", 29'h0400_0000, 8'd10, 1'b0, 6'd2,
                 29'h1000_0000, 8'd8, 1'b0, 1'b0, lat_of(2, 1'b0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
